// File: rtl/comp_rx.sv
// Receive end of the single-lane strobed serial link: checks strobe phase,
// reassembles LSB-first bursts into bytes and hands them out on valid/ready.
module comp_rx #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dqs_p,
  input  logic              dqs_n,
  input  logic              dq,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              frame_err,
  output logic              overflow,
  output logic [CNT_W-1:0]  rx_count
);

  localparam int unsigned BW = (DATA_W > 2) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    ERR
  } state_t;

  state_t            state, state_nxt;
  logic [BW-1:0]     bitcnt, bitcnt_nxt;
  logic [DATA_W-1:0] shreg, shreg_nxt;
  logic [DATA_W-1:0] data_nxt;
  logic              valid_nxt;
  logic              ferr_nxt;
  logic              ovf_nxt;
  logic [CNT_W-1:0]  count_nxt;
  logic              strobe_ok;
  logic              complete;

  always_comb begin
    state_nxt  = state;
    bitcnt_nxt = bitcnt;
    shreg_nxt  = shreg;
    data_nxt   = rx_data;
    valid_nxt  = rx_valid;
    ferr_nxt   = 1'b0;
    ovf_nxt    = 1'b0;
    count_nxt  = rx_count;
    complete   = 1'b0;
    // An unknown strobe makes this unknown, which takes the mismatch branch.
    strobe_ok  = (dqs_p == ~bitcnt[0]) && (dqs_n == bitcnt[0]);

    if (rx_valid && rx_ready) begin
      valid_nxt = 1'b0;
    end

    case (state)
      IDLE: begin
        if (dqs_p && !dqs_n) begin
          shreg_nxt    = '0;
          shreg_nxt[0] = dq;
          bitcnt_nxt   = BW'(1);
          state_nxt    = RECV;
        end
      end
      RECV: begin
        if (strobe_ok) begin
          shreg_nxt[bitcnt] = dq;
          bitcnt_nxt        = bitcnt + BW'(1);
          if (bitcnt == BW'(DATA_W - 1)) begin
            complete   = 1'b1;
            bitcnt_nxt = '0;
            state_nxt  = IDLE;
          end
        end else begin
          ferr_nxt   = 1'b1;
          shreg_nxt  = '0;
          bitcnt_nxt = '0;
          state_nxt  = ERR;
        end
      end
      ERR: begin
        if (dqs_p == dqs_n) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt  = IDLE;
        bitcnt_nxt = '0;
        shreg_nxt  = '0;
      end
    endcase

    // A byte accepted at this same edge frees the holding register for reload.
    if (complete) begin
      if (!rx_valid || rx_ready) begin
        data_nxt  = shreg_nxt;
        valid_nxt = 1'b1;
        count_nxt = rx_count + CNT_W'(1);
      end else begin
        ovf_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bitcnt    <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
      rx_count  <= '0;
    end else begin
      state     <= state_nxt;
      bitcnt    <= bitcnt_nxt;
      shreg     <= shreg_nxt;
      rx_data   <= data_nxt;
      rx_valid  <= valid_nxt;
      frame_err <= ferr_nxt;
      overflow  <= ovf_nxt;
      rx_count  <= count_nxt;
    end
  end

endmodule
